cnn_settle_capture: RTL and testbench

//  Downstream stage of the 4x4 cellular-network array. Watches the 16 cell outputs Y1..Y16 after
//  a run is launched and declares convergence once all outputs hold for STABLE_CYCLES cycles, or

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/cnn_out_serializer.sv | 66 ++++++
 rtl/cnn_settle_capture.sv | 128 ++++++++++++
 tb/tb_cnn_settle_capture.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and word helpers for the cellular-network
// settle/capture stage (Q4.4 signed cell words).
package cnn_pkg;

   localparam int WIDTH     = 9;
   localparam int N_CELLS   = 16;
   localparam int FRAC_BITS = 4;
   localparam int IDX_W     = 4;

   localparam logic [WIDTH-1:0] ONE     = 9'h010;
   localparam logic [WIDTH-1:0] NEG_ONE = 9'h1F0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WATCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Binarised pixel: strictly positive words map to 1, zero and negatives to 0.
   function automatic logic is_positive(input logic [WIDTH-1:0] word);
      return (word[WIDTH-1] == 1'b0) && (word != {WIDTH{1'b0}});
   endfunction

endpackage

// File: rtl/cnn_out_serializer.sv
// Snapshot store and one-cell-per-beat valid/ready streamer; all stream
// outputs are registered so nothing is combinational from out_ready.
module cnn_out_serializer
   import cnn_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [N_CELLS*WIDTH-1:0]   snap_in,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_bin,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
   output logic                       done
);

   logic [WIDTH-1:0] snap [N_CELLS];
   logic             beat;
   logic [IDX_W-1:0] idx_nxt;

   assign beat    = out_valid && out_ready;
   assign idx_nxt = out_idx + 4'd1;

   // Capture on load, then present the next word after every accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_CELLS; k++) begin
            snap[k] <= {WIDTH{1'b0}};
         end
         out_valid <= 1'b0;
         out_data  <= {WIDTH{1'b0}};
         out_bin   <= 1'b0;
         out_idx   <= {IDX_W{1'b0}};
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= beat && out_last;
         if (load) begin
            for (int k = 0; k < N_CELLS; k++) begin
               snap[k] <= snap_in[k*WIDTH +: WIDTH];
            end
            out_valid <= 1'b1;
            out_data  <= snap_in[WIDTH-1:0];
            out_bin   <= is_positive(snap_in[WIDTH-1:0]);
            out_idx   <= {IDX_W{1'b0}};
            out_last  <= 1'b0;
         end else if (beat) begin
            if (out_last) begin
               out_valid <= 1'b0;
               out_data  <= {WIDTH{1'b0}};
               out_bin   <= 1'b0;
               out_idx   <= {IDX_W{1'b0}};
               out_last  <= 1'b0;
            end else begin
               out_idx  <= idx_nxt;
               out_data <= snap[idx_nxt];
               out_bin  <= is_positive(snap[idx_nxt]);
               out_last <= (idx_nxt == 4'(N_CELLS-1));
            end
         end
      end
   end

endmodule

// File: rtl/cnn_settle_capture.sv
// Watches the 4x4 cell outputs after a launch, declares settle or timeout,
// then hands a frozen snapshot to the output serializer.
module cnn_settle_capture
   import cnn_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int MAX_CYCLES    = 255,
   parameter int CNT_W         = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [N_CELLS*WIDTH-1:0] y_in,
   output logic                     busy,
   output logic                     settled,
   output logic                     timeout,
   output logic [CNT_W-1:0]         cycles_used,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_bin,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_last,
   output logic                     done
);

   state_t                   state, state_next;
   logic [N_CELLS*WIDTH-1:0] prev;
   logic [CNT_W-1:0]         stable_cnt;
   logic [CNT_W-1:0]         cycle_cnt;
   logic                     match;
   logic                     accept;
   logic                     settle_hit;
   logic                     timeout_hit;
   logic                     load;

   assign match = (y_in == prev);

   // Next-state decode; settle is tested first so it wins a same-cycle tie.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      settle_hit  = 1'b0;
      timeout_hit = 1'b0;
      load        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ST_WATCH;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_WATCH: begin
            if (match && (stable_cnt == CNT_W'(STABLE_CYCLES-1))) begin
               settle_hit = 1'b1;
               load       = 1'b1;
               state_next = ST_DRAIN;
            end else if (cycle_cnt == CNT_W'(MAX_CYCLES-1)) begin
               timeout_hit = 1'b1;
               load        = 1'b1;
               state_next  = ST_DRAIN;
            end else begin
               state_next = ST_WATCH;
            end
         end
         ST_DRAIN: begin
            if (out_valid && out_ready && out_last) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_DRAIN;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, settle/timeout counters and sticky status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         prev        <= {(N_CELLS*WIDTH){1'b0}};
         stable_cnt  <= {CNT_W{1'b0}};
         cycle_cnt   <= {CNT_W{1'b0}};
         settled     <= 1'b0;
         timeout     <= 1'b0;
         cycles_used <= {CNT_W{1'b0}};
      end else begin
         state <= state_next;
         busy  <= (state_next != ST_IDLE);
         if (accept) begin
            prev       <= y_in;
            stable_cnt <= {CNT_W{1'b0}};
            cycle_cnt  <= {CNT_W{1'b0}};
            settled    <= 1'b0;
            timeout    <= 1'b0;
         end else if (state == ST_WATCH) begin
            prev       <= y_in;
            cycle_cnt  <= cycle_cnt + CNT_W'(1);
            stable_cnt <= match ? (stable_cnt + CNT_W'(1)) : {CNT_W{1'b0}};
            if (settle_hit) begin
               settled     <= 1'b1;
               cycles_used <= cycle_cnt + CNT_W'(1);
            end else if (timeout_hit) begin
               timeout     <= 1'b1;
               cycles_used <= CNT_W'(MAX_CYCLES);
            end
         end
      end
   end

   cnn_out_serializer u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .snap_in   (y_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_bin   (out_bin),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done)
   );

endmodule

// File: tb/tb_cnn_settle_capture.sv
// Scoreboard bench for cnn_settle_capture: directed images, expected beats
// queued at launch and popped by an independent stream monitor.
module tb_cnn_settle_capture;
   import cnn_pkg::*;

   localparam int BUS = N_CELLS*WIDTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, start, start5, out_ready;
   logic [BUS-1:0] y_in;

   logic busy, settled, timeout, out_valid, out_bin, out_last, done;
   logic [7:0] cycles_used;
   logic [WIDTH-1:0] out_data;
   logic [3:0] out_idx;

   logic busy5, settled5, timeout5, out_valid5, out_bin5, out_last5, done5;
   logic [7:0] cycles_used5;
   logic [WIDTH-1:0] out_data5;
   logic [3:0] out_idx5;

   cnn_settle_capture #(.STABLE_CYCLES(4), .MAX_CYCLES(20), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
      .busy(busy), .settled(settled), .timeout(timeout), .cycles_used(cycles_used),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_bin(out_bin), .out_idx(out_idx), .out_last(out_last), .done(done)
   );

   cnn_settle_capture #(.STABLE_CYCLES(4), .MAX_CYCLES(4), .CNT_W(8)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .y_in(y_in),
      .busy(busy5), .settled(settled5), .timeout(timeout5), .cycles_used(cycles_used5),
      .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5),
      .out_bin(out_bin5), .out_idx(out_idx5), .out_last(out_last5), .done(done5)
   );

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             bin;
      logic [3:0]       idx;
      logic             last;
   } beat_t;

   beat_t q[$];
   int errors = 0, checks = 0, beats = 0, done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stimulus images: 1 = centre +1.0 / border -1.0, 2 = same with Y1 toggling,
   // 3 = mixed words with Y16 changing before WATCH edge 3, 4 = mixed constant.
   function automatic logic [BUS-1:0] gen(input int mode, input int j);
      logic [BUS-1:0]   v;
      logic [3:0]       kk;
      logic [WIDTH-1:0] w;
      v = '0;
      for (int k = 0; k < N_CELLS; k++) begin
         kk = 4'(k);
         if (mode == 3 || mode == 4)
            w = (mode == 3 && j >= 3 && k == 15) ? 9'h100 : {kk[0], kk, kk};
         else if (k == 5 || k == 6 || k == 9 || k == 10)
            w = 9'h010;
         else
            w = 9'h1F0;
         if (mode == 2 && k == 0) w = (j % 2 == 1) ? 9'h0A5 : 9'h15A;
         v[k*WIDTH +: WIDTH] = w;
      end
      return v;
   endfunction

   task automatic expect_img(input logic [BUS-1:0] v);
      beat_t e;
      for (int k = 0; k < N_CELLS; k++) begin
         e.data = v[k*WIDTH +: WIDTH];
         e.bin  = ($signed(e.data) > 0);
         e.idx  = 4'(k);
         e.last = (k == N_CELLS-1);
         q.push_back(e);
      end
   endtask

   // Monitor: pops on every beat, checks held words during stalls and the done pulse.
   initial begin
      beat_t e;
      bit exp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_done = 1'b0;
         end else begin
            if (exp_done) begin
               chk("done_pulse", done, 1);
               exp_done = 1'b0;
            end else if (done) begin
               chk("spurious_done", done, 0);
            end
            if (done) done_cnt++;
            if (out_valid) begin
               if (q.size() == 0) begin
                  chk("sb_underflow", q.size(), 1);
               end else if (out_ready) begin
                  e = q.pop_front();
                  chk("beat_data", out_data, e.data);
                  chk("beat_bin",  out_bin,  e.bin);
                  chk("beat_idx",  out_idx,  e.idx);
                  chk("beat_last", out_last, e.last);
                  beats++;
                  if (out_last) exp_done = 1'b1;
               end else begin
                  chk("stall_data", out_data, q[0].data);
                  chk("stall_idx",  out_idx,  q[0].idx);
               end
            end
         end
      end
   end

   task automatic reset_checks(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_settled"}, settled, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_cycles"}, cycles_used, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_idx"}, out_idx, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_bin"}, out_bin, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // Launch a run and count WATCH edges until the status becomes visible.
   task automatic go(input int mode, input bit on5, output int n);
      y_in = gen(mode, 0);
      if (on5) start5 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start5 = 1'b0;
      n = 0;
      while (!(on5 ? (settled5 || timeout5) : (settled || timeout)) && n < 300) begin
         y_in = gen(mode, n + 1);
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic drain(input bit rnd, input bit perturb, input bit on5);
      int stall = 0;
      for (int c = 0; c < 400; c++) begin
         if (!(on5 ? busy5 : busy)) break;
         if (rnd) begin
            if (out_idx == 4'd5 && stall < 3) begin
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            out_ready = 1'b1;
         end
         if (perturb)
            y_in = gen(4, 0) ^ BUS'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
         @(posedge clk); #1;
      end
      chk("drain_end", on5 ? busy5 : busy, 0);
      out_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, b0, d0;
      rst_n = 1'b0; start = 1'b0; start5 = 1'b0; out_ready = 1'b0; y_in = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_checks("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: constant image, settle after 4 WATCH edges
      expect_img(gen(1, 0));
      b0 = beats; d0 = done_cnt;
      go(1, 1'b0, n);
      chk("t1_latency", n, 4);
      chk("t1_settled", settled, 1);
      chk("t1_timeout", timeout, 0);
      chk("t1_cycles", cycles_used, 4);
      chk("t1_valid", out_valid, 1);
      drain(1'b0, 1'b0, 1'b0);
      chk("t1_beats", beats - b0, 16);
      chk("t1_done", done_cnt - d0, 1);

      // 2: Y1 toggling -> timeout at 20, snapshot of the 20th edge
      expect_img(gen(2, 20));
      go(2, 1'b0, n);
      chk("t2_latency", n, 20);
      chk("t2_timeout", timeout, 1);
      chk("t2_settled", settled, 0);
      chk("t2_cycles", cycles_used, 20);
      drain(1'b0, 1'b0, 1'b0);

      // 3: change on WATCH edge 3 restarts the stable count
      expect_img(gen(3, 7));
      go(3, 1'b0, n);
      chk("t3_latency", n, 7);
      chk("t3_settled", settled, 1);
      chk("t3_cycles", cycles_used, 7);
      drain(1'b0, 1'b0, 1'b0);

      // 4: stalled/random ready, y_in perturbed during DRAIN
      expect_img(gen(4, 0));
      b0 = beats;
      go(4, 1'b0, n);
      chk("t4_latency", n, 4);
      drain(1'b1, 1'b1, 1'b0);
      chk("t4_beats", beats - b0, 16);
      chk("t4_sb_empty", q.size(), 0);

      // 5: settle and timeout coincide -> settled wins
      go(1, 1'b1, n);
      chk("t5_latency", n, 4);
      chk("t5_settled", settled5, 1);
      chk("t5_timeout", timeout5, 0);
      chk("t5_cycles", cycles_used5, 4);
      drain(1'b0, 1'b0, 1'b1);

      // 6: reset mid-DRAIN aborts the stream; start during DRAIN ignored
      expect_img(gen(1, 0));
      go(1, 1'b0, n);
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (out_idx == 4'd8) break;
         @(posedge clk); #1;
      end
      chk("t6_at_idx8", out_idx, 8);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      reset_checks("t6a");
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_checks("t6b");
      out_ready = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_no_done", done_cnt - d0, 0);

      expect_img(gen(1, 0));
      b0 = beats; d0 = done_cnt;
      go(1, 1'b0, n);
      chk("t6_latency", n, 4);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t6_busy", busy, 1);
      chk("t6_settled_kept", settled, 1);
      chk("t6_idx_kept", out_idx, 0);
      chk("t6_valid_kept", out_valid, 1);
      drain(1'b0, 1'b0, 1'b0);
      chk("t6_beats", beats - b0, 16);
      chk("t6_done", done_cnt - d0, 1);
      chk("t6_settled_sticky", settled, 1);
      chk("sb_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
